// File: rtl/bit_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module   : bit_stream_tx
//  Purpose  : Serial transmitter. Takes parallel words over valid/ready and
//             shifts them out MSB-first with a data_valid strobe.
//             Optional macro PATTERN_COUNT_EN adds a "1011" match counter.
//  Revision : 1.0  initial release
// ============================================================================
module bit_stream_tx #(
  parameter int WORD_W     = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              tx_enable,
  output logic              data_out,
  output logic              data_valid,
  output logic              busy,
  output logic [1:0]        state_out,
  output logic [15:0]       match_count
);

  localparam int                CNT_W      = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  C_LAST_IDX = CNT_W'(WORD_W - 1);
  localparam bit                C_HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [7:0]        C_GAP_LOAD = C_HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_shreg;
  logic [WORD_W-1:0] w_shreg_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  w_bit_cnt_nxt;
  logic [7:0]        r_gap_cnt;
  logic [7:0]        w_gap_cnt_nxt;
  logic              w_ready;
  logic              w_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_ready       = 1'b0;
    w_valid       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (word_valid) begin
          w_state_nxt   = S_SHIFT;
          w_shreg_nxt   = word_in;
          w_bit_cnt_nxt = C_LAST_IDX;
        end
      end
      S_SHIFT: begin
        w_valid = tx_enable;
        if (tx_enable) begin
          w_shreg_nxt   = {r_shreg[WORD_W-2:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
          if (r_bit_cnt == '0) begin
            w_bit_cnt_nxt = '0;
            if (C_HAS_GAP) begin
              w_state_nxt   = S_GAP;
              w_gap_cnt_nxt = C_GAP_LOAD;
            end else begin
              // Back-to-back reload: the next word's MSB follows with no bubble
              w_ready = 1'b1;
              if (word_valid) begin
                w_shreg_nxt   = word_in;
                w_bit_cnt_nxt = C_LAST_IDX;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign word_ready = w_ready;
  assign data_valid = w_valid;
  assign data_out   = r_shreg[WORD_W-1];
  assign busy       = (r_state != S_IDLE);
  assign state_out  = r_state;

`ifdef PATTERN_COUNT_EN
  logic [3:0]  r_hist;
  logic [3:0]  w_hist_nxt;
  logic [15:0] r_match_cnt;

  // History spans word boundaries and gaps; only reset clears it
  assign w_hist_nxt = {r_hist[2:0], r_shreg[WORD_W-1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist      <= '0;
      r_match_cnt <= '0;
    end else if (w_valid) begin
      r_hist <= w_hist_nxt;
      if (w_hist_nxt == 4'b1011) begin
        r_match_cnt <= r_match_cnt + 16'd1;
      end
    end
  end

  assign match_count = r_match_cnt;
`else
  assign match_count = 16'd0;
`endif

endmodule
`default_nettype wire
